// File: rtl/imem_responder.sv
// Instruction memory with a 2-entry in-order response buffer, valid/ready fetch
// handshake, branch flush and a program-load write port.
module imem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_pc,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } entry_t;

  logic [31:0] mem [DEPTH];
  entry_t      ent [2];
  logic        head;
  logic [1:0]  count;
  entry_t      fetch;
  logic        accept, xfer, tail;
  logic [IW-1:0] req_idx, ld_idx;

  // Full 32-bit compare so high address bits never alias into the index.
  function automatic logic fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  assign req_idx = req_addr[IW+1:2];
  assign ld_idx  = ld_addr[IW+1:2];

  assign req_ready = !reset && !ld_en && !flush && (count < 2'd2);
  assign rsp_valid = (count != 2'd0) && !flush;
  assign accept    = req_valid && req_ready;
  assign xfer      = rsp_valid && rsp_ready;
  assign tail      = head ^ count[0];

  assign rsp_instr = ent[head].instr;
  assign rsp_pc    = ent[head].pc;
  assign rsp_err   = ent[head].err;

  always_comb begin
    fetch.pc    = req_addr;
    fetch.err   = fault(req_addr);
    fetch.instr = fetch.err ? NOP_INSTR : mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      head   <= 1'b0;
      ent[0] <= '0;
      ent[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (accept) ent[tail] <= fetch;
      if (xfer)   head      <= ~head;
      count <= count + 2'(accept) - 2'(xfer);
    end
  end

  // Buffered entries hold captured data, so a later load never disturbs them.
  always_ff @(posedge clk) begin
    if (!reset && ld_en && !fault(ld_addr)) mem[ld_idx] <= ld_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: directed vector table, hand sequences for multi-cycle
// corners, and randomized traffic against a queue-based reference model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic        flush, ld_en;
  logic [31:0] req_addr, rsp_instr, rsp_pc, ld_addr, ld_data;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(256), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err), .flush(flush),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } rsp_t;

  logic [31:0] ref_mem [256];
  rsp_t        q [$];

  logic        s_ready, s_valid, s_err;
  logic [31:0] s_instr, s_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rsp_t ref_fetch(input logic [31:0] a);
    rsp_t r;
    r.pc    = a;
    r.err   = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd256);
    r.instr = r.err ? 32'h00000013 : ref_mem[a[9:2]];
    return r;
  endfunction

  // One clock cycle: drive, sample at negedge against the model, advance model.
  task automatic cyc(input logic rst, input logic rv, input logic [31:0] a,
                     input logic rr, input logic fl, input logic ld,
                     input logic [31:0] la, input logic [31:0] ld_d);
    logic e_ready, e_valid;
    reset = rst; req_valid = rv; req_addr = a; rsp_ready = rr;
    flush = fl; ld_en = ld; ld_addr = la; ld_data = ld_d;
    @(negedge clk);
    s_ready = req_ready; s_valid = rsp_valid; s_err = rsp_err;
    s_instr = rsp_instr; s_pc = rsp_pc;
    e_ready = !rst && !ld && !fl && (q.size() < 2);
    e_valid = (q.size() > 0) && !fl;
    chk("model_req_ready", 32'(s_ready), 32'(e_ready));
    if (!rst) chk("model_rsp_valid", 32'(s_valid), 32'(e_valid));
    if (!rst && e_valid) begin
      chk("model_rsp_instr", s_instr, q[0].instr);
      chk("model_rsp_pc", s_pc, q[0].pc);
      chk("model_rsp_err", 32'(s_err), 32'(q[0].err));
    end
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (e_valid && rr) void'(q.pop_front());
      if (e_ready && rv) q.push_back(ref_fetch(a));
      if (fl) q.delete();
      if (ld && la[1:0] == 2'b00 && (la >> 2) < 32'd256) ref_mem[la[9:2]] = ld_d;
    end
    #1;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic req(input logic [31:0] a, input logic rr);
    cyc(1'b0, 1'b1, a, rr, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] a;
    logic        rr;
    logic        ld;
    logic [31:0] la;
    logic [31:0] ld_d;
    logic        e_ready;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    else if (r == 7) return $urandom;
    else if (r == 8) return (32'd256 + 32'($urandom_range(0, 4000))) << 2;
    else             return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
  endfunction

  initial begin
    tbl[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8, 32'h33333333, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[3] = '{1'b1, 32'h0,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   32'h0};
    tbl[4] = '{1'b1, 32'h4,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,   32'h11111111};
    tbl[5] = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h4,   32'h22222222};
    tbl[6] = '{1'b1, 32'h2,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h8,   32'h33333333};
    tbl[7] = '{1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h2,   32'h00000013};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h400, 32'h00000013};
    tbl[9] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   32'h0};

    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(1'b0);
    chk("reset_rsp_valid", 32'(s_valid), 32'h0);
    chk("reset_rsp_err", 32'(s_err), 32'h0);
    chk("reset_rsp_instr", s_instr, 32'h0);
    chk("reset_rsp_pc", s_pc, 32'h0);

    for (int i = 0; i < 256; i++)
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'(i) << 2, $urandom);

    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, tbl[i].rv, tbl[i].a, tbl[i].rr, 1'b0, tbl[i].ld, tbl[i].la, tbl[i].ld_d);
      chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d_err", i), 32'(s_err), 32'(tbl[i].e_err));
      end
    end

    // Backpressure: two accepted, third stalls with head held stable.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    req(32'h8, 1'b0);
    chk("bp_ready_full", 32'(s_ready), 32'h0);
    chk("bp_hold_pc0", s_pc, 32'h0);
    req(32'h8, 1'b0);
    chk("bp_hold_pc1", s_pc, 32'h0);
    req(32'h8, 1'b1);
    chk("bp_ready_no_rsp_dep", 32'(s_ready), 32'h0);
    req(32'h8, 1'b1);
    chk("bp_ready_after", 32'(s_ready), 32'h1);
    chk("bp_order_pc", s_pc, 32'h4);
    idle(1'b1);
    chk("bp_last_pc", s_pc, 32'h8);
    idle(1'b1);

    // Flush with two responses pending.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("flush_valid", 32'(s_valid), 32'h0);
    chk("flush_ready", 32'(s_ready), 32'h0);
    idle(1'b1);
    chk("flush_after_valid", 32'(s_valid), 32'h0);
    req(32'h8, 1'b1);
    chk("flush_req_valid", 32'(s_valid), 32'h0);
    idle(1'b1);
    chk("flush_new_instr", s_instr, 32'h33333333);
    idle(1'b1);
    chk("flush_only_one", 32'(s_valid), 32'h0);

    // Load over a word whose fetch is already buffered.
    req(32'h4, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h4, 32'h44444444);
    idle(1'b1);
    chk("ld_old_instr", s_instr, 32'h22222222);
    req(32'h4, 1'b1);
    idle(1'b1);
    chk("ld_new_instr", s_instr, 32'h44444444);

    // Reset mid-flight, with a load that must be blocked.
    req(32'h0, 1'b0);
    req(32'h4, 1'b0);
    cyc(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hdeadbeef);
    idle(1'b1);
    chk("rst_mid_valid", 32'(s_valid), 32'h0);
    chk("rst_mid_pc", s_pc, 32'h0);
    chk("rst_mid_instr", s_instr, 32'h0);
    req(32'h0, 1'b1);
    chk("rst_mid_valid2", 32'(s_valid), 32'h0);
    idle(1'b1);
    chk("rst_mem_kept", s_instr, 32'h11111111);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), rand_addr(),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) == 0), rand_addr(), $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit instruction words stored.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h00000013, giving the substitute instruction returned on a faulting fetch.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a fetch request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a fetch request this cycle.
REQ-007 The block SHALL have port req_addr, input, 32 bits: fetch byte address (the PC).
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: a fetch response is present.
REQ-009 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response this cycle.
REQ-010 The block SHALL have port rsp_instr, output, 32 bits: the fetched instruction word.
REQ-011 The block SHALL have port rsp_pc, output, 32 bits: the req_addr of the request this response answers.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: the fetch was misaligned or out of range.
REQ-013 The block SHALL have port flush, input, 1 bit: discard all outstanding fetches (branch redirect).
REQ-014 The block SHALL have port ld_en, input, 1 bit: program-load write strobe.
REQ-015 The block SHALL have port ld_addr, input, 32 bits: program-load byte address.
REQ-016 The block SHALL have port ld_data, input, 32 bits: program-load data word.

Function
REQ-017 Request handshake: accept occurs when req_valid && req_ready are both high at a rising edge; response transfer occurs when rsp_valid && rsp_ready are both high at a rising edge.
REQ-018 Outstanding count = accepted requests not yet transferred and not flushed; range 0..2.
REQ-019 req_ready SHALL equal !ld_en && !flush && (outstanding < 2), with no other dependency (in particular none on rsp_ready).
REQ-020 Memory SHALL be read once, at accept; the entry {instr, pc, err} SHALL be stored in a 2-entry in-order response buffer.
REQ-021 A request accepted at edge N SHALL first present rsp_valid=1 in the cycle after edge N, provided no older response is pending.
REQ-022 Throughput: with rsp_ready held high, one accept and one transfer per cycle SHALL be sustained.
REQ-023 Responses SHALL be returned in accept order.
REQ-024 While rsp_valid=1 && rsp_ready=0, rsp_instr, rsp_pc and rsp_err SHALL hold stable.
REQ-025 A simultaneous accept and transfer in the same cycle SHALL leave outstanding unchanged.
REQ-026 A fault is req_addr[1:0] != 0 or (req_addr >> 2) >= DEPTH.
REQ-027 On a fault: rsp_err=1 and rsp_instr=NOP_INSTR.
REQ-028 Without a fault: rsp_err=0 and rsp_instr=mem[req_addr >> 2].
REQ-029 Flush cycle: rsp_valid SHALL be forced to 0 and no accept shall occur.
REQ-030 Flush effect: at the flush edge, outstanding SHALL become 0 and all buffered entries SHALL be discarded.
REQ-031 The first post-flush request SHALL be accepted no earlier than the cycle after flush.
REQ-032 Load write: when ld_en=1, mem[ld_addr >> 2] SHALL be written with ld_data at the edge, but only if ld_addr is aligned and in range; otherwise the write is silently ignored.
REQ-033 Load/fetch interaction: no fetch is accepted in a cycle with ld_en=1; responses already buffered SHALL keep their captured data after a write to the same word.
REQ-034 Load and flush may be asserted together; both effects SHALL apply independently.
REQ-035 Address bits above the index width SHALL only affect the range check, never wrap into the index.

Reset
REQ-036 At a reset edge, outstanding SHALL become 0 and the buffer SHALL be emptied; the cycle after, rsp_valid=0 and rsp_err=0.
REQ-037 After reset, rsp_instr=0 and rsp_pc=0.
REQ-038 During a reset cycle, req_ready=0.
REQ-039 Reset SHALL NOT clear memory contents.
REQ-040 Reset asserted mid-operation SHALL drop all outstanding responses; none SHALL appear after reset deasserts.
REQ-041 A load write is blocked during a reset cycle.

Verification
REQ-042 Load words 0x11111111 @0x0, 0x22222222 @0x4, 0x33333333 @0x8; fetch 0x0, 0x4, 0x8 back-to-back with rsp_ready=1 -> three responses on consecutive cycles, first one cycle after the first accept, pcs 0x0/0x4/0x8, err=0.
REQ-043 rsp_ready=0, issue 3 requests -> two accepted, then req_ready=0 with rsp_pc=0x0 held stable; raise rsp_ready -> req_ready=1 in the following cycle, responses in order.
REQ-044 Fetch 0x2 and then 0x400 (DEPTH=256) -> both responses give rsp_err=1 and rsp_instr=0x00000013.
REQ-045 Two responses outstanding; assert flush one cycle -> rsp_valid=0 in the flush cycle and after; then fetch 0x8 -> the only response is 0x33333333.
REQ-046 Load 0x44444444 @0x4 while a buffered response for 0x4 is pending -> that response returns 0x22222222; a new fetch of 0x4 returns 0x44444444.
REQ-047 Reset with two responses outstanding -> rsp_valid=0 the cycle after reset and afterwards; fetch 0x0 post-reset -> 0x11111111 (memory kept).
